// File: rtl/uart_rx_os_fifo.sv
// uart_rx_os_fifo
// Oversampling 8N1 UART receiver with a first-word-fall-through byte FIFO.
// A 16x tick is derived from the 12 MHz clock for one of four baud rates.
// Each bit is decided by a majority vote of the samples at ticks 7, 8 and 9.
// Good frames are queued; a bad stop bit raises frame_err and waits for the
// line to go idle again.
//
// Ports:
//   clk_i         system clock (12 MHz)
//   nrst_i        synchronous active-low reset
//   baud_i        rate select: 00=110, 01=600, 10=2400, 11=9600
//   rx_i          asynchronous serial line, idles high
//   rd_en_i       consumer pop request (ignored while empty)
//   rd_data_o     FIFO head byte, 0 while empty
//   rd_valid_o    FIFO not empty
//   fifo_count_o  bytes currently held (0..DEPTH)
//   frame_err_o   one-cycle pulse on a bad stop bit
//   overflow_o    one-cycle pulse when a byte is dropped on a full FIFO
//   busy_o        a frame is in progress
module uart_rx_os_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic [1:0]    baud_i,
  input  logic          rx_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          rd_valid_o,
  output logic [CW-1:0] fifo_count_o,
  output logic          frame_err_o,
  output logic          overflow_o,
  output logic          busy_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;

  logic          rx_meta_q, rx_s_q;
  logic [1:0]    baud_q;
  logic [12:0]   div_cnt_q, div_cnt_d, div_last;
  logic [2:0]    state_q, state_d;
  logic [3:0]    sample_cnt_q, sample_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          samp7_q, samp7_d, samp8_q, samp8_d;
  logic          frame_err_q, overflow_q;
  logic          baud_chg, tick, maj, push_req, ferr_req;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, pop, do_write;

  // Terminal count of the 16x tick divider for the selected rate.
  always_comb begin
    case (baud_q)
      2'b00:   div_last = 13'd6817;
      2'b01:   div_last = 13'd1249;
      2'b10:   div_last = 13'd311;
      default: div_last = 13'd77;
    endcase
  end

  // A rate change restarts the divider and abandons any frame in flight.
  assign baud_chg = (baud_i != baud_q);
  assign tick     = !baud_chg && (div_cnt_q == div_last);
  assign maj      = (samp7_q & samp8_q) | (samp7_q & rx_s_q) | (samp8_q & rx_s_q);

  always_comb begin
    if (baud_chg || tick) div_cnt_d = '0;
    else                  div_cnt_d = div_cnt_q + 13'd1;
  end

  // Receive FSM: moves only on ticks; sample_cnt is the tick index within
  // the current bit, and the vote is resolved at index 9.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    samp7_d      = samp7_q;
    samp8_d      = samp8_q;
    push_req     = 1'b0;
    ferr_req     = 1'b0;
    if (baud_chg) begin
      state_d      = S_IDLE;
      sample_cnt_d = '0;
    end else if (tick) begin
      if (state_q == S_IDLE) begin
        if (!rx_s_q) begin
          state_d      = S_START;
          sample_cnt_d = '0;
        end
      end else if (state_q == S_BRK) begin
        if (rx_s_q) state_d = S_IDLE;
      end else begin
        sample_cnt_d = sample_cnt_q + 4'd1;
        if (sample_cnt_q == 4'd7) samp7_d = rx_s_q;
        if (sample_cnt_q == 4'd8) samp8_d = rx_s_q;
        case (state_q)
          S_START: begin
            if (sample_cnt_q == 4'd9 && maj) begin
              state_d      = S_IDLE;
              sample_cnt_d = '0;
            end else if (sample_cnt_q == 4'd15) begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end
          end
          S_DATA: begin
            if (sample_cnt_q == 4'd9) shift_d = {maj, shift_q[7:1]};
            if (sample_cnt_q == 4'd15) begin
              if (bit_idx_q == 3'd7) state_d = S_STOP;
              else                   bit_idx_d = bit_idx_q + 3'd1;
            end
          end
          S_STOP: begin
            if (sample_cnt_q == 4'd9) begin
              sample_cnt_d = '0;
              if (maj) begin
                push_req = 1'b1;
                state_d  = S_IDLE;
              end else begin
                ferr_req = 1'b1;
                state_d  = S_BRK;
              end
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Synchroniser, divider and FSM state.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      baud_q       <= baud_i;
      div_cnt_q    <= '0;
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      samp7_q      <= 1'b1;
      samp8_q      <= 1'b1;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_i;
      rx_s_q       <= rx_meta_q;
      baud_q       <= baud_i;
      div_cnt_q    <= div_cnt_d;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      samp7_q      <= samp7_d;
      samp8_q      <= samp8_d;
      frame_err_q  <= ferr_req;
    end
  end

  // A full FIFO still accepts a byte if the head leaves in the same cycle.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = rd_en_i && !empty;
  assign do_write = push_req && (!full || pop);

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_req && full && !pop;
      if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_write && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !do_write) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk_i) begin
    if (nrst_i && do_write) mem[wr_ptr_q] <= shift_q;
  end

  assign rd_data_o    = empty ? 8'h00 : mem[rd_ptr_q];
  assign rd_valid_o   = !empty;
  assign fifo_count_o = count_q;
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_os_fifo.md
Name: uart_rx_os_fifo

Overview:
- Oversampling UART receive front-end with a byte FIFO, for a 12 MHz system clock.
- Sits upstream of the UART buffer/echo stage. Recovers 8N1 frames from the rx pin at one of four selectable baud rates and queues received bytes.
- The consumer pops bytes through a first-word-fall-through valid/ready read port.

Parameters:
- DEPTH, 8, FIFO depth in bytes (power of two, 2..16).
- CW, 4, width of fifo_count; must hold DEPTH.

Ports:
- clk  input  1  system clock, 12 MHz.
- nrst  input  1  reset, synchronous, active-low.
- baud  input  2  rate select: 00=110, 01=600, 10=2400, 11=9600.
- rx  input  1  asynchronous serial line; idles high.
- rd_en  input  1  consumer pop request.
- rd_data  output  8  FIFO head byte; valid when rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- fifo_count  output  CW  bytes currently held.
- frame_err  output  1  one-cycle pulse when a bad stop bit is detected.
- overflow  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.
- busy  output  1  high while a frame is in progress (state other than IDLE).

Behaviour:
- Reset (nrst=0 at a clk edge):
  - state=IDLE; FIFO empty, pointers 0.
  - rd_valid=0, fifo_count=0, frame_err=0, overflow=0, busy=0, rd_data=0.
  - Sync flops=1; tick counter=0.
  - Reset mid-frame discards the partial byte and the FIFO contents.
- Input sync: rx passes through 2 flops, giving rx_s. All decisions use rx_s.
- 16x tick generator:
  - DIV is 6818 / 1250 / 312 / 78 for baud 00 / 01 / 10 / 11.
  - The counter runs 0..DIV-1. tick=1 for one clk when counter==DIV-1, then the counter wraps to 0.
  - baud is registered as baud_q. If baud != baud_q, the counter clears, state goes to IDLE, the partial byte is dropped, and the FIFO is untouched.
- Sampling: each bit spans 16 ticks, indexed by sample_cnt 0..15. The bit value is the majority of rx_s at ticks 7, 8 and 9, decided at tick 9.
- FSM (advances only on tick):
  - IDLE: rx_s=0 -> START with sample_cnt=0.
  - START: at tick 9, majority=1 is a false start -> IDLE with no flags. Otherwise continue; at sample_cnt=15 -> DATA with bit_idx=0.
  - DATA: 8 bits, LSB first, shifted into the shift register at tick 9. At sample_cnt=15: bit_idx 7 -> STOP, else bit_idx+1.
  - STOP: at tick 9:
    - majority=1: push the byte -> IDLE. This early return to IDLE allows resync on the next start edge.
    - majority=0: frame_err pulse, byte discarded -> BRK.
  - BRK: wait until rx_s=1 on a tick -> IDLE. Frame_err is not repeated.
- FIFO:
  - Push occurs in the cycle after the STOP decision tick, so rd_valid rises 1 clk after that tick when the FIFO was empty.
  - rd_data=mem[rd_ptr] combinationally (FWFT).
  - Pop occurs when rd_en=1 and rd_valid=1. rd_en while empty is ignored.
  - Push while full with no pop: byte dropped, overflow pulses 1 clk, contents unchanged.
  - Push while full with a pop in the same cycle: both happen, fifo_count stays DEPTH, no overflow.
  - Push and pop in the same cycle while not full and not empty: count unchanged.
  - Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- busy=1 in START, DATA, STOP and BRK.

Test Plan:
- baud=11, send 0x55 (start, 1,0,1,0,1,0,1,0, stop) at 1248 clk/bit -> after the stop decision, rd_valid=1 and rd_data=0x55. Pulse rd_en for 1 clk -> rd_valid=0 and fifo_count=0.
- baud=11, drive rx low for 234 clk (3 ticks) then high -> busy rises then falls within 1 bit time; fifo_count=0; frame_err never pulses.
- baud=01, send 0xA5 with stop bit 0, holding rx low for 2 more bit times -> exactly one frame_err pulse; fifo_count=0; busy stays 1 until rx returns high; a following 0x3C is received correctly.
- baud=10, send 9 bytes 0x01..0x09 with rd_en=0 -> fifo_count=8, one overflow pulse during byte 9. Draining gives 0x01..0x08 in order.
- FIFO full, then assert rd_en in the exact push cycle of a new byte 0x77 -> no overflow; fifo_count=8; 0x77 is read last.
- Mid-byte (bit 4 of 0xF0), assert nrst=0 for 1 clk -> all outputs at reset values. A subsequent full frame 0x81 is received with no frame_err.
